// File: rtl/pid_integ_ss.sv
// ---------------------------------------------------------------------------
// pid_integ_ss
// Front-end stage of the pitch PID. Clamps the incoming pitch sample to a
// 10-bit signed error and adds it into an 18-bit signed integrator. An add
// that would overflow is rejected. The block also runs the soft-start ramp
// timer that the downstream math stage uses to scale motor drive.
//
// Ports
//   clk        : system clock, rising-edge
//   rst        : synchronous reset, active-high
//   vld        : one-cycle strobe, ptch is a new sample
//   ptch[15:0] : signed pitch sample
//   rider_off  : rider not detected, clears the integrator
//   pwr_up     : drive enabled; low clears the integrator and the ramp
//   integrator : signed accumulated error (PID math input)
//   integ_vld  : one-cycle pulse, aligned with stable integrator after a sample
//   integ_ovf  : one-cycle pulse, a sample was rejected for signed overflow
//   ss_tmr     : top 8 bits of the soft-start counter
//   ss_done    : high while the soft-start FSM is in RUN
// ---------------------------------------------------------------------------
module pid_integ_ss #(
    parameter int SS_W = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld,
    input  logic [15:0] ptch,
    input  logic        rider_off,
    input  logic        pwr_up,
    output logic [17:0] integrator,
    output logic        integ_vld,
    output logic        integ_ovf,
    output logic [7:0]  ss_tmr,
    output logic        ss_done
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_RAMP = 2'b01,
        ST_RUN  = 2'b10
    } ss_state_t;

    localparam logic [SS_W-1:0] SS_ONES = {SS_W{1'b1}};
    localparam logic [SS_W-1:0] SS_ONE  = {{(SS_W-1){1'b0}}, 1'b1};
    localparam logic [SS_W-1:0] SS_ZERO = {SS_W{1'b0}};

    // Integrator datapath state
    logic [17:0] integrator_q, integrator_d;
    logic        upd_q, upd_d;           // a sample was consumed last edge
    logic        ovf_pend_q, ovf_pend_d; // that sample was rejected
    logic        integ_vld_q, integ_vld_d;
    logic        integ_ovf_q, integ_ovf_d;

    // Soft-start state
    ss_state_t   state_q, state_d;
    logic [SS_W-1:0] ss_cnt_q, ss_cnt_d;
    logic        ss_done_q, ss_done_d;

    // Saturation and adder
    logic [9:0]  ptch_sat;
    logic [17:0] err_ext;
    logic [17:0] sum;
    logic        add_ovf;

    // Clamp the pitch sample into the 10-bit signed range and sign-extend it
    always_comb begin
        ptch_sat = ptch[9:0];
        if ($signed(ptch) > $signed(16'sd511)) begin
            ptch_sat = 10'h1FF;
        end else if ($signed(ptch) < $signed(-16'sd512)) begin
            ptch_sat = 10'h200;
        end else begin
            ptch_sat = ptch[9:0];
        end
    end

    assign err_ext = {{8{ptch_sat[9]}}, ptch_sat};
    assign sum     = integrator_q + err_ext;
    // Same-sign operands producing an opposite-sign result is a signed overflow
    assign add_ovf = (integrator_q[17] == err_ext[17]) && (sum[17] != integrator_q[17]);

    // Integrator next state: clear beats sample; overflow holds the value
    always_comb begin
        integrator_d = integrator_q;
        upd_d        = 1'b0;
        ovf_pend_d   = 1'b0;
        if (rider_off || !pwr_up) begin
            integrator_d = 18'h00000;
        end else if (vld) begin
            upd_d = 1'b1;
            if (add_ovf) begin
                ovf_pend_d   = 1'b1;
                integrator_d = integrator_q;
            end else begin
                integrator_d = sum;
            end
        end else begin
            integrator_d = integrator_q;
        end
    end

    // Status pulses trail the update by one edge so they line up with the
    // already-stable integrator value
    always_comb begin
        integ_vld_d = upd_q;
        integ_ovf_d = ovf_pend_q;
    end

    // Soft-start FSM next state: ramp the counter to all-ones and park there
    always_comb begin
        state_d  = state_q;
        ss_cnt_d = ss_cnt_q;
        if (!pwr_up) begin
            state_d  = ST_OFF;
            ss_cnt_d = SS_ZERO;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d  = ST_RAMP;
                    ss_cnt_d = SS_ONE;
                end
                ST_RAMP: begin
                    if (ss_cnt_q == SS_ONES) begin
                        state_d  = ST_RUN;
                        ss_cnt_d = ss_cnt_q;
                    end else begin
                        state_d  = ST_RAMP;
                        ss_cnt_d = ss_cnt_q + SS_ONE;
                    end
                end
                ST_RUN: begin
                    state_d  = ST_RUN;
                    ss_cnt_d = SS_ONES;
                end
                default: begin
                    state_d  = ST_OFF;
                    ss_cnt_d = SS_ZERO;
                end
            endcase
        end
        ss_done_d = (state_d == ST_RUN);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            integrator_q <= 18'h00000;
            upd_q        <= 1'b0;
            ovf_pend_q   <= 1'b0;
            integ_vld_q  <= 1'b0;
            integ_ovf_q  <= 1'b0;
            state_q      <= ST_OFF;
            ss_cnt_q     <= SS_ZERO;
            ss_done_q    <= 1'b0;
        end else begin
            integrator_q <= integrator_d;
            upd_q        <= upd_d;
            ovf_pend_q   <= ovf_pend_d;
            integ_vld_q  <= integ_vld_d;
            integ_ovf_q  <= integ_ovf_d;
            state_q      <= state_d;
            ss_cnt_q     <= ss_cnt_d;
            ss_done_q    <= ss_done_d;
        end
    end

    assign integrator = integrator_q;
    assign integ_vld  = integ_vld_q;
    assign integ_ovf  = integ_ovf_q;
    assign ss_tmr     = ss_cnt_q[SS_W-1 -: 8];
    assign ss_done    = ss_done_q;

endmodule
